seq_array_multiplier: RTL and testbench

Parametrised, multi-cycle shift-and-add multiplier. It is the sequential successor to the fixed 3x3 combinational array multiplier.
- Supports any operand width and a per-operation signed/unsigned mode.
- Uses a start/busy/done handshake so it can sit on a shared datapath bus without a wide combinational path.
- One product per WIDTH+2 cycles, back-to-back capable.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_shift_add_dp.sv | 71 +++++++
 rtl/seq_array_multiplier.sv | 146 ++++++++++++++
 tb/tb_seq_array_multiplier.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mult_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Width of the iteration counter for a given operand width (never below 1 bit).
  function automatic int count_width(input int width);
    if (width > 2) begin
      return $clog2(width);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-and-add datapath: magnitude capture, accumulate/shift register,
// WIDTH+1-bit adder with kept carry, and final conditional negate.
module mult_shift_add_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               signed_eff,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result
);

  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] acc_r;     // {acc_hi, mplr}
  logic               neg_r;
  logic [WIDTH:0]     addend_s;
  logic [WIDTH:0]     sum_s;

  // Unsigned magnitude; the most-negative value maps to 2^(WIDTH-1), which still fits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    if (s && v[WIDTH-1]) begin
      return ~v + WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

  // Partial-product add into the upper half, carry kept in the extra bit.
  always_comb begin
    addend_s = '0;
    if (acc_r[0]) begin
      addend_s = {1'b0, mcand_r};
    end else begin
      addend_s = '0;
    end
    sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + addend_s;
  end

  // Operand capture on load, one add-and-shift iteration per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r <= '0;
      acc_r   <= '0;
      neg_r   <= 1'b0;
    end else if (load) begin
      mcand_r <= magnitude(a, signed_eff);
      acc_r   <= {{WIDTH{1'b0}}, magnitude(b, signed_eff)};
      neg_r   <= signed_eff & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      acc_r   <= {sum_s, acc_r[WIDTH-1:1]};
    end else begin
      acc_r   <= acc_r;
    end
  end

  // Restore the sign; negating zero yields zero, so a zero operand needs no special case.
  always_comb begin
    result = acc_r;
    if (neg_r) begin
      result = ~acc_r + (2*WIDTH)'(1);
    end else begin
      result = acc_r;
    end
  end

endmodule

// File: rtl/seq_array_multiplier.sv
// Multi-cycle signed/unsigned shift-and-add multiplier with start/busy/done handshake.
// Fixed latency of WIDTH+2 cycles start-to-start, back-to-back capable.
module seq_array_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic               overflow_hint
);

  localparam int             CW             = count_width(WIDTH);
  localparam logic [CW-1:0]  LAST_COUNT     = CW'(WIDTH - 1);
  localparam logic           SIGNED_ALLOWED = (SIGNED_EN != 0);

  state_e             state_r;
  state_e             state_s;
  logic [CW-1:0]      count_r;
  logic               load_s;
  logic               step_s;
  logic               seff_s;
  logic               seff_r;
  logic [2*WIDTH-1:0] result_s;
  logic [WIDTH:0]     top_bits_s;
  logic               ovf_s;
  logic               busy_r;
  logic               done_r;
  logic [2*WIDTH-1:0] p_r;
  logic               ovf_r;

  assign seff_s = signed_mode & SIGNED_ALLOWED;

  mult_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_s),
    .step       (step_s),
    .signed_eff (seff_s),
    .a          (a),
    .b          (b),
    .result     (result_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath control; start is only looked at in IDLE.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          state_s = ST_CALC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        step_s = 1'b1;
        if (count_r == LAST_COUNT) begin
          state_s = ST_FIN;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Iteration counter and latched effective signedness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
      seff_r  <= 1'b0;
    end else if (load_s) begin
      count_r <= '0;
      seff_r  <= seff_s;
    end else if (state_r == ST_CALC) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Signed product fits in WIDTH bits only if its top WIDTH+1 bits are all equal.
  always_comb begin
    top_bits_s = result_s[2*WIDTH-1:WIDTH-1];
    ovf_s      = 1'b0;
    if (seff_r) begin
      ovf_s = ~((&top_bits_s) | ~(|top_bits_s));
    end else begin
      ovf_s = 1'b0;
    end
  end

  // Registered handshake and result; p/overflow_hint only update when leaving FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      p_r    <= '0;
      ovf_r  <= 1'b0;
    end else begin
      busy_r <= (state_s != ST_IDLE);
      done_r <= (state_r == ST_FIN);
      if (state_r == ST_FIN) begin
        p_r   <= result_s;
        ovf_r <= ovf_s;
      end else begin
        p_r   <= p_r;
        ovf_r <= ovf_r;
      end
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign p             = p_r;
  assign overflow_hint = ovf_r;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed bench for seq_array_multiplier: a 3-bit instance for handshake corners,
// and two 8-bit instances (signed enabled / disabled) sharing a vector table.
module tb_seq_array_multiplier;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 3-bit instance
  logic       s3_start, s3_sm;
  logic [2:0] s3_a, s3_b;
  logic       busy3, done3, ovf3;
  logic [5:0] p3;

  // 8-bit instances share inputs
  logic        s8_start, s8_sm;
  logic [7:0]  s8_a, s8_b;
  logic        busy8s, done8s, ovf8s;
  logic [15:0] p8s;
  logic        busy8u, done8u, ovf8u;
  logic [15:0] p8u;

  seq_array_multiplier #(.WIDTH(3), .SIGNED_EN(1)) u3 (
    .clk(clk), .rst_n(rst_n), .start(s3_start), .signed_mode(s3_sm),
    .a(s3_a), .b(s3_b), .busy(busy3), .done(done3), .p(p3), .overflow_hint(ovf3));

  seq_array_multiplier #(.WIDTH(8), .SIGNED_EN(1)) u8s (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .signed_mode(s8_sm),
    .a(s8_a), .b(s8_b), .busy(busy8s), .done(done8s), .p(p8s), .overflow_hint(ovf8s));

  seq_array_multiplier #(.WIDTH(8), .SIGNED_EN(0)) u8u (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .signed_mode(s8_sm),
    .a(s8_a), .b(s8_b), .busy(busy8u), .done(done8u), .p(p8u), .overflow_hint(ovf8u));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] ps;   // expected p, SIGNED_EN=1
    logic        ovs;  // expected overflow_hint, SIGNED_EN=1
    logic [15:0] pu;   // expected p, SIGNED_EN=0
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n;
    int cnt;

    vecs[0] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b0, 16'h04F1}; // -3*5
    vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h4000, 1'b1, 16'h4000}; // -128*-128
    vecs[2] = '{1'b1, 8'h7F, 8'hFF, 16'hFF81, 1'b0, 16'h7E81}; // 127*-1
    vecs[3] = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0, 16'hFE01}; // -1*-1
    vecs[4] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 16'hFE01}; // unsigned 255*255
    vecs[5] = '{1'b0, 8'h00, 8'hC8, 16'h0000, 1'b0, 16'h0000}; // zero
    vecs[6] = '{1'b1, 8'h00, 8'h80, 16'h0000, 1'b0, 16'h0000}; // 0*-128, -0=0
    vecs[7] = '{1'b1, 8'h10, 8'h10, 16'h0100, 1'b1, 16'h0100}; // 16*16
    vecs[8] = '{1'b1, 8'hF0, 8'h08, 16'hFF80, 1'b0, 16'h0780}; // -16*8 = -128 fits
    vecs[9] = '{1'b1, 8'hC0, 8'hFE, 16'h0080, 1'b1, 16'hBE80}; // -64*-2 = 128 overflows

    rst_n = 1'b0;
    s3_start = 1'b0; s3_sm = 1'b0; s3_a = 3'd0; s3_b = 3'd0;
    s8_start = 1'b0; s8_sm = 1'b0; s8_a = 8'd0; s8_b = 8'd0;

    // Reset state
    #12;
    chk("rst_busy3", {31'd0, busy3}, 32'd0);
    chk("rst_done3", {31'd0, done3}, 32'd0);
    chk("rst_p3",    {26'd0, p3},    32'd0);
    chk("rst_ovf3",  {31'd0, ovf3},  32'd0);
    chk("rst_busy8", {31'd0, busy8s}, 32'd0);
    chk("rst_p8",    {16'd0, p8s},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // W=3 single op 4*6
    @(negedge clk);
    s3_a = 3'd4; s3_b = 3'd6; s3_sm = 1'b0; s3_start = 1'b1;
    @(posedge clk); #1;
    s3_start = 1'b0;
    cnt = busy3 ? 1 : 0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (busy3) cnt++;
    end while (!done3 && n < 30);
    chk("w3_latency", n, 32'd4);
    chk("w3_p_4x6", {26'd0, p3}, 32'd24);
    chk("w3_ovf", {31'd0, ovf3}, 32'd0);
    chk("w3_busy_cycles", cnt, 32'd4);
    @(posedge clk); #1;
    chk("w3_done_pulse", {31'd0, done3}, 32'd0);
    chk("w3_p_hold", {26'd0, p3}, 32'd24);

    // W=3 back-to-back, start held high
    @(negedge clk);
    s3_a = 3'd6; s3_b = 3'd6; s3_start = 1'b1;
    @(posedge clk); #1;
    s3_a = 3'd7; s3_b = 3'd7;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done3 && n < 30);
    chk("b2b_lat1", n, 32'd4);
    chk("b2b_p_6x6", {26'd0, p3}, 32'd36);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) begin s3_a = 3'd3; s3_b = 3'd2; end
    end while (!done3 && n < 30);
    chk("b2b_gap2", n, 32'd5);
    chk("b2b_p_7x7", {26'd0, p3}, 32'd49);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) s3_start = 1'b0;
    end while (!done3 && n < 30);
    chk("b2b_gap3", n, 32'd5);
    chk("b2b_p_3x2", {26'd0, p3}, 32'd6);
    cnt = 0;
    repeat (8) begin @(posedge clk); #1; if (done3) cnt++; end
    chk("b2b_no_extra_done", cnt, 32'd0);

    // W=3 start pulsed mid-CALC is ignored
    @(negedge clk);
    s3_a = 3'd5; s3_b = 3'd3; s3_start = 1'b1;
    @(posedge clk); #1;
    s3_start = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) begin s3_start = 1'b1; s3_a = 3'd7; s3_b = 3'd7; end
      if (n == 2) s3_start = 1'b0;
    end while (!done3 && n < 30);
    chk("mid_start_lat", n, 32'd4);
    chk("mid_start_p", {26'd0, p3}, 32'd15);
    cnt = 0;
    repeat (8) begin @(posedge clk); #1; if (done3) cnt++; end
    chk("mid_start_no_done", cnt, 32'd0);

    // W=8 table, signed-enabled and signed-disabled instances in parallel
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s8_a = vecs[i].a; s8_b = vecs[i].b; s8_sm = vecs[i].sm; s8_start = 1'b1;
      @(posedge clk); #1;
      s8_start = 1'b0;
      chk($sformatf("v%0d_busy", i), {31'd0, busy8s}, 32'd1);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!done8s && n < 40);
      chk($sformatf("v%0d_latency", i), n, 32'd9);
      chk($sformatf("v%0d_p_signed", i), {16'd0, p8s}, {16'd0, vecs[i].ps});
      chk($sformatf("v%0d_ovf_signed", i), {31'd0, ovf8s}, {31'd0, vecs[i].ovs});
      chk($sformatf("v%0d_done_unsigned", i), {31'd0, done8u}, 32'd1);
      chk($sformatf("v%0d_p_unsigned", i), {16'd0, p8u}, {16'd0, vecs[i].pu});
      chk($sformatf("v%0d_ovf_unsigned", i), {31'd0, ovf8u}, 32'd0);
    end

    // Async reset mid-CALC aborts the operation
    @(negedge clk);
    s8_a = 8'd3; s8_b = 8'd3; s8_sm = 1'b0; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy8s}, 32'd0);
    chk("arst_done", {31'd0, done8s}, 32'd0);
    chk("arst_p_signed", {16'd0, p8s}, 32'd0);
    chk("arst_p_unsigned", {16'd0, p8u}, 32'd0);
    chk("arst_ovf", {31'd0, ovf8s}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (15) begin @(posedge clk); #1; if (done8s || busy8s) cnt++; end
    chk("arst_no_done", cnt, 32'd0);

    // Fresh operation after reset
    @(negedge clk);
    s8_a = 8'd12; s8_b = 8'd11; s8_sm = 1'b0; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done8s && n < 40);
    chk("post_rst_latency", n, 32'd9);
    chk("post_rst_p", {16'd0, p8s}, 32'd132);
    chk("post_rst_ovf", {31'd0, ovf8s}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
